// File: rtl/key_filter.sv
// rtl/key_filter.sv - multi-channel active-low push-button debouncer
// Two-flop synchroniser, then an independent filter FSM and counter per key.
module key_filter #(
  parameter int          KEY_W   = 2,
  parameter logic [24:0] CNT_MAX = 25'd999_999,
  parameter int          CNT_W   = 25
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 25'd1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FILTER,
    DOWN,
    RELEASE_FILTER
  } state_t;

  logic [KEY_W-1:0] r_sync1;
  logic [KEY_W-1:0] r_sync2;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < KEY_W; g++) begin : g_ch
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_key;
    logic             w_key_nxt;
    logic             r_press;
    logic             w_press_nxt;
    logic             r_release;
    logic             w_release_nxt;
    logic             w_s;

    assign w_s = r_sync2[g];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_key     <= 1'b1;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_key     <= w_key_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
      end
    end

    // Any opposite-level sample inside a filter state discards the whole window.
    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_key_nxt     = r_key;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_s) begin
            w_state_nxt = PRESS_FILTER;
            w_cnt_nxt   = '0;
          end
        end
        PRESS_FILTER: begin
          if (w_s) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = DOWN;
            w_key_nxt   = 1'b0;
            w_press_nxt = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        DOWN: begin
          if (w_s) begin
            w_state_nxt = RELEASE_FILTER;
            w_cnt_nxt   = '0;
          end
        end
        RELEASE_FILTER: begin
          if (!w_s) begin
            w_state_nxt = DOWN;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt   = IDLE;
            w_key_nxt     = 1'b1;
            w_release_nxt = 1'b1;
            w_cnt_nxt     = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign key_state[g]   = r_key;
    assign key_press[g]   = r_press;
    assign key_release[g] = r_release;
  end

endmodule

// File: tb/tb_key_filter.sv
// tb/tb_key_filter.sv - scoreboard bench for key_filter
// Reference: a level flips once CNT_MAX+1 consecutive synchronised samples disagree with it.
module tb_key_filter;

  localparam int KEY_W   = 2;
  localparam int CNT_MAX = 25;
  localparam int LAT     = CNT_MAX + 2;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic [KEY_W-1:0] key_in  = '1;
  logic [KEY_W-1:0] key_state;
  logic [KEY_W-1:0] key_press;
  logic [KEY_W-1:0] key_release;

  key_filter #(
    .KEY_W  (KEY_W),
    .CNT_MAX(25'd25),
    .CNT_W  (25)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    int         cyc;
    logic [1:0] p;
    logic [1:0] r;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] m_s1 = '1;
  logic [1:0] m_s2 = '1;
  logic [1:0] m_level = '1;
  int         m_run[KEY_W];
  int         last_press_cyc[KEY_W];
  int         last_rel_cyc[KEY_W];
  int         press_cnt[KEY_W];
  int         rel_cnt[KEY_W];

  // Reference model
  initial begin
    logic [1:0] s_seen;
    logic [1:0] p;
    logic [1:0] r;
    for (int i = 0; i < KEY_W; i++) m_run[i] = 0;
    forever begin
      @(posedge sys_clk);
      cyc++;
      if (sys_rst) begin
        m_s1 = '1;
        m_s2 = '1;
        m_level = '1;
        for (int i = 0; i < KEY_W; i++) m_run[i] = 0;
      end else begin
        s_seen = m_s2;
        m_s2 = m_s1;
        m_s1 = key_in;
        p = '0;
        r = '0;
        for (int ch = 0; ch < KEY_W; ch++) begin
          if (s_seen[ch] != m_level[ch]) begin
            m_run[ch]++;
            if (m_run[ch] == CNT_MAX + 1) begin
              if (m_level[ch]) p[ch] = 1'b1;
              else r[ch] = 1'b1;
              m_level[ch] = ~m_level[ch];
              m_run[ch] = 0;
            end
          end else begin
            m_run[ch] = 0;
          end
        end
        if ((p | r) != '0) exp_q.push_back('{cyc, p, r});
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    for (int i = 0; i < KEY_W; i++) begin
      last_press_cyc[i] = -1;
      last_rel_cyc[i] = -1;
      press_cnt[i] = 0;
      rel_cnt[i] = 0;
    end
    forever begin
      @(posedge sys_clk);
      #5;
      n_checks++;
      if (key_state !== m_level) begin
        n_fail++;
        $display("FAIL key_state cyc=%0d actual=%b required=%b", cyc, key_state, m_level);
      end
      n_checks++;
      if ((key_press & key_release) != '0) begin
        n_fail++;
        $display("FAIL strobe_overlap cyc=%0d press=%b release=%b required no overlap",
                 cyc, key_press, key_release);
      end
      if ((key_press | key_release) != '0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe cyc=%0d press=%b release=%b required none",
                   cyc, key_press, key_release);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.p !== key_press || e.r !== key_release) begin
            n_fail++;
            $display("FAIL strobe cyc=%0d press=%b release=%b required cyc=%0d press=%b release=%b",
                     cyc, key_press, key_release, e.cyc, e.p, e.r);
          end
        end
        for (int ch = 0; ch < KEY_W; ch++) begin
          if (key_press[ch]) begin
            last_press_cyc[ch] = cyc;
            press_cnt[ch]++;
          end
          if (key_release[ch]) begin
            last_rel_cyc[ch] = cyc;
            rel_cnt[ch]++;
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        e = exp_q.pop_front();
        $display("FAIL missed_strobe cyc=%0d required press=%b release=%b at cyc=%0d",
                 cyc, e.p, e.r, e.cyc);
      end
    end
  end

  task automatic hold(input logic [1:0] v, input int n);
    key_in = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check_int(input string name, input int actual, input int required);
    n_checks++;
    if (actual != required) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  initial begin
    int onset;
    int pc;
    int rc;
    int tmr[KEY_W];
    logic [1:0] v;

    // 1. reset
    @(negedge sys_clk);
    hold(2'b11, 10);
    sys_rst = 1'b0;
    hold(2'b11, 40);
    check_int("no_strobe_after_reset", press_cnt[0] + press_cnt[1] + rel_cnt[0] + rel_cnt[1], 0);

    // 2. clean press / release on key 0
    onset = cyc + 1;
    hold(2'b10, 100);
    check_int("press0_latency", last_press_cyc[0], onset + LAT);
    check_int("press0_count", press_cnt[0], 1);
    check_int("press1_none", press_cnt[1], 0);
    onset = cyc + 1;
    hold(2'b11, 60);
    check_int("release0_latency", last_rel_cyc[0], onset + LAT);
    check_int("release0_count", rel_cnt[0], 1);

    // 3. bounce rejection on key 1
    pc = press_cnt[1];
    rc = rel_cnt[1];
    hold(2'b01, 10); hold(2'b11, 3);
    hold(2'b01, 20); hold(2'b11, 3);
    hold(2'b01, 24); hold(2'b11, 60);
    check_int("bounce_press1", press_cnt[1], pc);
    check_int("bounce_release1", rel_cnt[1], rc);

    // 4. bounce then settle
    hold(2'b01, 5); hold(2'b11, 2);
    onset = cyc + 1;
    hold(2'b01, 80);
    check_int("settle_press1_latency", last_press_cyc[1], onset + LAT);
    check_int("settle_press1_count", press_cnt[1], pc + 1);
    hold(2'b11, 60);

    // 5. simultaneous keys
    onset = cyc + 1;
    hold(2'b00, 60);
    check_int("simul_press0", last_press_cyc[0], onset + LAT);
    check_int("simul_press1", last_press_cyc[1], onset + LAT);
    hold(2'b11, 60);

    // 6. reset mid-filter with key 0 still held
    pc = press_cnt[0];
    hold(2'b10, 12);
    sys_rst = 1'b1;
    hold(2'b10, 4);
    sys_rst = 1'b0;
    onset = cyc + 1;
    hold(2'b10, 60);
    check_int("rst_mid_press_count", press_cnt[0], pc + 1);
    check_int("rst_mid_press_latency", last_press_cyc[0], onset + LAT);
    hold(2'b11, 60);

    // Random phase
    for (int i = 0; i < KEY_W; i++) tmr[i] = 1;
    v = 2'b11;
    for (int t = 0; t < 4000; t++) begin
      for (int ch = 0; ch < KEY_W; ch++) begin
        tmr[ch]--;
        if (tmr[ch] == 0) begin
          v[ch] = ~v[ch];
          tmr[ch] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(26, 70))
                                                : int'($urandom_range(1, 30));
        end
      end
      if (t == 1500) begin
        sys_rst = 1'b1;
        hold(v, 3);
        sys_rst = 1'b0;
      end
      hold(v, 1);
    end
    hold(2'b11, 80);
    check_int("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
